// File: rtl/cr_cddip_supportPKG.sv
// Shared types and default widths for the CDDIP support-core admission/drain control.
package cr_cddip_supportPKG;

  localparam int CDDIP_CNT_W = 8;
  localparam int CDDIP_TMR_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    QUIESCED = 2'd2,
    TIMEOUT  = 2'd3
  } quiesce_state_e;

endpackage

// File: rtl/cddip_inflight_cnt.sv
// Saturating up/down counter of commands in flight, with a sticky
// flag for any attempt to step past either end of the range.
module cddip_inflight_cnt
  import cr_cddip_supportPKG::*;
#(
  parameter int CNT_W = CDDIP_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] next_cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic ovf;
  logic unf;

  // Simultaneous inc and dec cancel, so neither end can be crossed.
  always_comb begin
    next_cnt = cnt;
    ovf      = 1'b0;
    unf      = 1'b0;
    if (inc && !dec) begin
      if (cnt == CNT_MAX) ovf = 1'b1;
      else                next_cnt = cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt == '0) unf = 1'b1;
      else           next_cnt = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= next_cnt;
      if (ovf || unf) err <= 1'b1;
    end
  end

endmodule

// File: rtl/cddip_quiesce_ctl.sv
// Admission throttle and quiesce/drain sequencer for the CDDIP command pipe.
//   state    | meaning
//   RUN      | admission allowed up to the in-flight limit
//   DRAIN    | admission off, waiting for pipe to empty, watchdog running
//   QUIESCED | pipe empty and halted, quiesce_ack high
//   TIMEOUT  | watchdog expired while draining, admission still off
module cddip_quiesce_ctl
  import cr_cddip_supportPKG::*;
#(
  parameter int CNT_W = CDDIP_CNT_W,
  parameter int TMR_W = CDDIP_TMR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_max_inflight,
  input  logic [TMR_W-1:0] cfg_drain_timeout,
  input  logic             quiesce_req,
  input  logic             halt_req,
  input  logic             isf_sup_rqe_rx,
  input  logic             osf_sup_cqe_exit,
  input  logic             comp_busy,
  output logic             isf_admit_en,
  output logic             quiesce_ack,
  output logic             drain_timeout_int,
  output logic             cnt_err,
  output logic [1:0]       ctl_state,
  output logic [CNT_W-1:0] inflight_cnt
);

  localparam logic [TMR_W-1:0] TMR_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  quiesce_state_e   state;
  quiesce_state_e   nxt_state;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] nxt_timer;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic [CNT_W-1:0] eff_max;
  logic             any_req;
  logic             drained;
  logic             tmo_hit;
  logic             nxt_tint;

  cddip_inflight_cnt #(
    .CNT_W (CNT_W)
  ) u_inflight_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (isf_sup_rqe_rx),
    .dec      (osf_sup_cqe_exit),
    .cnt      (cnt),
    .next_cnt (nxt_cnt),
    .err      (cnt_err)
  );

  assign inflight_cnt = cnt;
  assign ctl_state    = state;
  assign eff_max      = (cfg_max_inflight == '0) ? CNT_MAX : cfg_max_inflight;
  assign any_req      = quiesce_req || halt_req;
  assign drained      = (nxt_cnt == '0) && !comp_busy;
  assign tmo_hit      = (cfg_drain_timeout != '0) &&
                        (timer == (cfg_drain_timeout - TMR_W'(1)));

  always_comb begin
    nxt_state = state;
    nxt_timer = timer;
    nxt_tint  = 1'b0;
    case (state)
      RUN: begin
        if (any_req) begin
          nxt_state = DRAIN;
          nxt_timer = '0;
        end
      end
      DRAIN: begin
        if (timer != TMR_MAX) nxt_timer = timer + TMR_W'(1);
        // An empty pipe beats a watchdog expiry landing in the same cycle.
        if (drained) begin
          nxt_state = QUIESCED;
        end else if (tmo_hit) begin
          nxt_state = TIMEOUT;
          nxt_tint  = 1'b1;
        end else if (!any_req) begin
          nxt_state = RUN;
        end
      end
      QUIESCED: begin
        if (nxt_cnt != '0) begin
          nxt_state = DRAIN;
          nxt_timer = '0;
        end else if (!any_req) begin
          nxt_state = RUN;
        end
      end
      TIMEOUT: begin
        if (drained)       nxt_state = QUIESCED;
        else if (!any_req) nxt_state = RUN;
      end
      default: nxt_state = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= RUN;
      timer             <= '0;
      isf_admit_en      <= 1'b0;
      quiesce_ack       <= 1'b0;
      drain_timeout_int <= 1'b0;
    end else begin
      state             <= nxt_state;
      timer             <= nxt_timer;
      isf_admit_en      <= (nxt_state == RUN) && (nxt_cnt < eff_max);
      quiesce_ack       <= (nxt_state == QUIESCED);
      drain_timeout_int <= nxt_tint;
    end
  end

endmodule

// File: tb/tb_cddip_quiesce_ctl.sv
// Directed and randomized bench for cddip_quiesce_ctl against a cycle-level
// reference model built from elapsed-drain-time and occupancy rules.
module tb_cddip_quiesce_ctl;

  localparam int CNT_W = 8;
  localparam int TMR_W = 16;
  localparam int CMAX  = 255;
  localparam int M_RUN = 0, M_DRAIN = 1, M_QUI = 2, M_TMO = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] cfg_max_inflight;
  logic [TMR_W-1:0] cfg_drain_timeout;
  logic             quiesce_req;
  logic             halt_req;
  logic             isf_sup_rqe_rx;
  logic             osf_sup_cqe_exit;
  logic             comp_busy;
  logic             isf_admit_en;
  logic             quiesce_ack;
  logic             drain_timeout_int;
  logic             cnt_err;
  logic [1:0]       ctl_state;
  logic [CNT_W-1:0] inflight_cnt;

  cddip_quiesce_ctl #(
    .CNT_W (CNT_W),
    .TMR_W (TMR_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_max_inflight  (cfg_max_inflight),
    .cfg_drain_timeout (cfg_drain_timeout),
    .quiesce_req       (quiesce_req),
    .halt_req          (halt_req),
    .isf_sup_rqe_rx    (isf_sup_rqe_rx),
    .osf_sup_cqe_exit  (osf_sup_cqe_exit),
    .comp_busy         (comp_busy),
    .isf_admit_en      (isf_admit_en),
    .quiesce_ack       (quiesce_ack),
    .drain_timeout_int (drain_timeout_int),
    .cnt_err           (cnt_err),
    .ctl_state         (ctl_state),
    .inflight_cnt      (inflight_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: occupancy, phase, and cycles spent in the current drain.
  int m_cnt, m_state, m_elapsed;
  bit m_err, m_admit, m_ack, m_tint;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_state = M_RUN; m_elapsed = 0;
    m_err = 0; m_admit = 0; m_ack = 0; m_tint = 0;
  endtask

  task automatic model_tick();
    int nc, ns, emax;
    bit req, drained, expire;
    req = quiesce_req || halt_req;
    nc  = m_cnt;
    if (isf_sup_rqe_rx && !osf_sup_cqe_exit) begin
      if (m_cnt < CMAX) nc = m_cnt + 1; else m_err = 1;
    end else if (osf_sup_cqe_exit && !isf_sup_rqe_rx) begin
      if (m_cnt > 0) nc = m_cnt - 1; else m_err = 1;
    end
    drained = (nc == 0) && !comp_busy;
    expire  = (int'(cfg_drain_timeout) != 0) && (m_elapsed + 1 == int'(cfg_drain_timeout));
    ns = m_state;
    m_tint = 0;
    if (m_state == M_RUN) begin
      if (req) ns = M_DRAIN;
    end else if (m_state == M_DRAIN) begin
      if (drained)     ns = M_QUI;
      else if (expire) begin ns = M_TMO; m_tint = 1; end
      else if (!req)   ns = M_RUN;
    end else if (m_state == M_QUI) begin
      if (nc != 0)     ns = M_DRAIN;
      else if (!req)   ns = M_RUN;
    end else begin
      if (drained)     ns = M_QUI;
      else if (!req)   ns = M_RUN;
    end
    if (ns == M_DRAIN && m_state != M_DRAIN) m_elapsed = 0;
    else if (m_state == M_DRAIN)             m_elapsed++;
    emax    = (int'(cfg_max_inflight) == 0) ? CMAX : int'(cfg_max_inflight);
    m_admit = (ns == M_RUN) && (nc < emax);
    m_ack   = (ns == M_QUI);
    m_cnt   = nc;
    m_state = ns;
  endtask

  task automatic compare_all();
    chk("admit_en", 32'(isf_admit_en),      32'(m_admit));
    chk("ack",      32'(quiesce_ack),       32'(m_ack));
    chk("tmo_int",  32'(drain_timeout_int), 32'(m_tint));
    chk("cnt_err",  32'(cnt_err),           32'(m_err));
    chk("state",    32'(ctl_state),         32'(m_state));
    chk("count",    32'(inflight_cnt),      32'(m_cnt));
  endtask

  task automatic cyc(input bit rqe, input bit cqe);
    @(negedge clk);
    isf_sup_rqe_rx   = rqe;
    osf_sup_cqe_exit = cqe;
    @(posedge clk);
    model_tick();
    #1;
    compare_all();
    isf_sup_rqe_rx   = 1'b0;
    osf_sup_cqe_exit = 1'b0;
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    rst = 1'b1;
    cfg_max_inflight = 8'd3; cfg_drain_timeout = '0;
    quiesce_req = 0; halt_req = 0; comp_busy = 0;
    isf_sup_rqe_rx = 0; osf_sup_cqe_exit = 0;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(0, 0);
    chk("t0_admit_after_reset", 32'(isf_admit_en), 32'd1);

    // 1: limit throttling
    repeat (3) cyc(1, 0);
    chk("t1_admit_full", 32'(isf_admit_en), 32'd0);
    cyc(0, 1);
    chk("t1_admit_reopen", 32'(isf_admit_en), 32'd1);
    chk("t1_count", 32'(inflight_cnt), 32'd2);

    // 2: software quiesce and drain
    quiesce_req = 1;
    cyc(0, 0);
    chk("t2_drain", 32'(ctl_state), 32'd1);
    for (int i = 0; i < 10; i++) cyc(0, (i == 3) || (i == 7));
    chk("t2_quiesced", 32'(ctl_state), 32'd2);
    chk("t2_ack", 32'(quiesce_ack), 32'd1);
    quiesce_req = 0;
    cyc(0, 0);
    chk("t2_run", 32'(ctl_state), 32'd0);
    chk("t2_admit", 32'(isf_admit_en), 32'd1);

    // 3: drain watchdog
    cfg_drain_timeout = 16'd20;
    cyc(1, 0);
    halt_req = 1;
    cyc(0, 0);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(0, 0);
      if (drain_timeout_int) begin n = i; break; end
    end
    chk("t3_tmo_latency", 32'(n), 32'd20);
    chk("t3_state_tmo", 32'(ctl_state), 32'd3);
    cyc(0, 0);
    chk("t3_no_repeat", 32'(drain_timeout_int), 32'd0);
    cyc(0, 1);
    chk("t3_quiesced", 32'(ctl_state), 32'd2);
    halt_req = 0;
    cyc(0, 0);

    // 4: underflow and overflow saturation
    cyc(0, 1);
    chk("t4_underflow_cnt", 32'(inflight_cnt), 32'd0);
    chk("t4_underflow_err", 32'(cnt_err), 32'd1);
    cfg_max_inflight = 8'd0;
    repeat (256) cyc(1, 0);
    chk("t4_sat_cnt", 32'(inflight_cnt), 32'd255);
    chk("t4_err_sticky", 32'(cnt_err), 32'd1);
    repeat (250) cyc(0, 1);

    // 5: simultaneous pulses; exit colliding with expiry
    cyc(1, 1);
    chk("t5_hold5", 32'(inflight_cnt), 32'd5);
    repeat (4) cyc(0, 1);
    halt_req = 1;
    cyc(0, 0);
    repeat (19) cyc(0, 0);
    cyc(0, 1);
    chk("t5_collide_state", 32'(ctl_state), 32'd2);
    chk("t5_collide_no_int", 32'(drain_timeout_int), 32'd0);
    halt_req = 0;
    cyc(0, 0);

    // 6: reset in the middle of a drain
    repeat (4) cyc(1, 0);
    comp_busy = 1; quiesce_req = 1;
    cyc(0, 0);
    repeat (3) cyc(0, 0);
    chk("t6_in_drain", 32'(ctl_state), 32'd1);
    async_reset();
    chk("t6_rst_cnt", 32'(inflight_cnt), 32'd0);
    chk("t6_rst_err", 32'(cnt_err), 32'd0);
    quiesce_req = 0; comp_busy = 0;
    cyc(0, 0);
    chk("t6_run", 32'(ctl_state), 32'd0);
    chk("t6_admit", 32'(isf_admit_en), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0)  quiesce_req = ~quiesce_req;
      if ($urandom_range(0, 59) == 0)  halt_req = ~halt_req;
      if ($urandom_range(0, 9) == 0)   comp_busy = ~comp_busy;
      if ($urandom_range(0, 199) == 0) cfg_max_inflight = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 199) == 0) cfg_drain_timeout = 16'($urandom_range(0, 25));
      if (i == 1500) async_reset();
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cddip_quiesce_ctl.md
Name: cddip_quiesce_ctl

Overview:
Admission and drain controller for the CDDIP command pipeline, placed between the ISF request path and the support core.
- Tracks commands in flight from ISF request-receive and OSF completion-exit pulses.
- Throttles new-command admission against a programmable in-flight limit.
- Sequences a software- or error-initiated quiesce (stop admission, drain, acknowledge), with a drain watchdog.

Parameters:
CNT_W, 8, width of in-flight counter and limit (max 2^CNT_W-1 commands)
TMR_W, 16, width of drain watchdog timer and timeout config

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
cfg_max_inflight  in  CNT_W  in-flight limit; 0 = no limit (treated as 2^CNT_W-1)
cfg_drain_timeout  in  TMR_W  drain watchdog cycles; 0 = watchdog disabled
quiesce_req  in  1  software quiesce request, level
halt_req  in  1  error halt request, level (driven from pre-interrupt)
isf_sup_rqe_rx  in  1  one-cycle pulse, command accepted into pipe
osf_sup_cqe_exit  in  1  one-cycle pulse, completion left pipe
comp_busy  in  1  completion-queue entries outstanding
isf_admit_en  out  1  ISF may accept a new command
quiesce_ack  out  1  pipe drained and halted
drain_timeout_int  out  1  one-cycle pulse on watchdog expiry
cnt_err  out  1  sticky, counter underflow/overflow seen
ctl_state  out  2  FSM state encoding
inflight_cnt  out  CNT_W  current in-flight count

Behaviour:
- Reset (rst=1, asynchronous):
  - All outputs 0; ctl_state=RUN; inflight_cnt=0; timer=0.
  - isf_admit_en=0 during reset; it asserts on the first cycle after deassertion once conditions hold.
- In-flight counter:
  - rqe_rx only: +1. cqe_exit only: -1. Both or neither: hold.
  - Increment at all-ones: hold and set cnt_err. Decrement at 0: hold at 0 and set cnt_err.
  - cnt_err clears only on reset.
  - The counter counts rqe_rx regardless of isf_admit_en, so the one-cycle skid is absorbed.
- State encoding: RUN=0, DRAIN=1, QUIESCED=2, TIMEOUT=3.
- RUN:
  - If halt_req or quiesce_req: go to DRAIN and clear the timer.
- DRAIN (admission off):
  - Timer increments each cycle and saturates.
  - Checks are evaluated in this priority order:
    1. next_cnt==0 and !comp_busy: go to QUIESCED (wins over timeout in the same cycle).
    2. cfg_drain_timeout!=0 and timer==cfg_drain_timeout-1: go to TIMEOUT and pulse drain_timeout_int for one cycle.
    3. Both quiesce_req and halt_req low: return to RUN.
- QUIESCED:
  - quiesce_ack=1.
  - Stray rqe_rx sets next_cnt!=0: return to DRAIN and clear the timer.
  - Both requests low: go to RUN; quiesce_ack drops the same cycle the state leaves.
- TIMEOUT:
  - Admission stays off.
  - next_cnt==0 and !comp_busy: go to QUIESCED.
  - Both requests low: go to RUN.
  - No repeat interrupt pulse.
- isf_admit_en is registered:
  - Set to (next_state==RUN) && (next_cnt < eff_max), where eff_max = (cfg_max_inflight==0) ? all-ones : cfg_max_inflight.
  - Latency is one clock from the causing pulse or request.
- halt_req has the same effect as quiesce_req; either request holds the block out of RUN.
- cfg_* are quasi-static. A change takes effect on the next comparison; no glitch protection is required.
- Reset mid-DRAIN: immediate return to RUN with count 0, and no timeout pulse.

Decomposition:
- Shared package (cr_cddip_supportPKG):
  - quiesce_state_e enum (RUN/DRAIN/QUIESCED/TIMEOUT).
  - Constants for the default CNT_W/TMR_W.
- One natural sub-module: cddip_inflight_cnt, a saturating up/down counter with error flag, parameterised by CNT_W.
- The FSM and timer stay in the top module.

Test Plan:
1. Set cfg_max_inflight=3 and send 3 rqe_rx pulses -> isf_admit_en=0 the cycle after the 3rd pulse. Then one cqe_exit -> admit_en=1 one cycle later, inflight_cnt=2.
2. Set quiesce_req=1 with count=2, send 2 cqe_exit over 10 cycles with comp_busy=0 -> ctl_state 0→1→2, quiesce_ack=1. Drop the request -> RUN with admit_en=1.
3. Set cfg_drain_timeout=20, halt_req=1, count=1 and no exit -> drain_timeout_int pulses exactly 20 cycles after DRAIN entry and ctl_state=3. A later cqe_exit -> QUIESCED.
4. Send a cqe_exit with count=0 -> cnt stays 0 and cnt_err=1 (sticky). Send 256 rqe_rx without exits -> cnt holds 255.
5. Simultaneous rqe_rx and cqe_exit at count=5 -> count stays 5. Exit and timeout expiring in the same cycle with next_cnt=0 -> QUIESCED and no interrupt.
6. Assert rst in DRAIN with count=4 -> all outputs 0 asynchronously. After release -> RUN, count=0, admit_en=1.
